// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: requester, ALU-side and response signals of the shared-ALU arbiter
interface alu_rr_arbiter_if #(
  parameter int N = 16
);
  logic req0_valid;
  logic req0_ready;
  logic [N-1:0] req0_A;
  logic [N-1:0] req0_B;
  logic [3:0] req0_op;
  logic req1_valid;
  logic req1_ready;
  logic [N-1:0] req1_A;
  logic [N-1:0] req1_B;
  logic [3:0] req1_op;
  logic [N-1:0] alu_A;
  logic [N-1:0] alu_B;
  logic [3:0] alu_opcode;
  logic [N-1:0] alu_result;
  logic alu_Z;
  logic alu_C;
  logic alu_Nf;
  logic alu_V;
  logic rsp_valid;
  logic rsp_id;
  logic [N-1:0] rsp_result;
  logic rsp_Z;
  logic rsp_C;
  logic rsp_Nf;
  logic rsp_V;
  modport slave (
    input req0_valid, req0_A, req0_B, req0_op,
    input req1_valid, req1_A, req1_B, req1_op,
    output req0_ready, req1_ready,
    output alu_A, alu_B, alu_opcode,
    input alu_result, alu_Z, alu_C, alu_Nf, alu_V,
    output rsp_valid, rsp_id, rsp_result, rsp_Z, rsp_C, rsp_Nf, rsp_V
  );
  modport master (
    output req0_valid, req0_A, req0_B, req0_op,
    output req1_valid, req1_A, req1_B, req1_op,
    input req0_ready, req1_ready,
    input alu_A, alu_B, alu_opcode,
    output alu_result, alu_Z, alu_C, alu_Nf, alu_V,
    input rsp_valid, rsp_id, rsp_result, rsp_Z, rsp_C, rsp_Nf, rsp_V
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin, credit-limited sharing of one LAT-cycle ALU by two requesters; ALU_ARB_STATS_EN adds stall counters
module alu_rr_arbiter #(
  parameter int N = 16,
  parameter int LAT = 3,
  parameter int MAX_OUT = 2
) (
  input logic clk,
  input logic rst,
  alu_rr_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] stall0_cnt,
  output logic [15:0] stall1_cnt
`endif
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  logic [CW-1:0] cnt0, cnt1;
  logic last_grant, el0, el1, win, acc, done0, done1;
  logic [LAT-1:0] tag_v, tag_id;
  logic [N-1:0] a_q, b_q;
  logic [3:0] op_q;
  always_comb begin
    el0 = !rst && bus.req0_valid && cnt0 < MAX_C;
    el1 = !rst && bus.req1_valid && cnt1 < MAX_C;
    win = el0 && el1 ? !last_grant : el1;
    acc = el0 || el1;
    done0 = tag_v[LAT-1] && !tag_id[LAT-1];
    done1 = tag_v[LAT-1] && tag_id[LAT-1];
  end
  assign bus.req0_ready = acc && !win;
  assign bus.req1_ready = acc && win;
  assign bus.alu_A = acc ? (win ? bus.req1_A : bus.req0_A) : a_q;
  assign bus.alu_B = acc ? (win ? bus.req1_B : bus.req0_B) : b_q;
  assign bus.alu_opcode = acc ? (win ? bus.req1_op : bus.req0_op) : op_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
      last_grant <= 1'b1;
      tag_v <= '0;
      tag_id <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_result <= '0;
      {bus.rsp_Z, bus.rsp_C, bus.rsp_Nf, bus.rsp_V} <= 4'b0;
    end else begin
      if (acc) begin
        last_grant <= win;
        a_q <= bus.alu_A;
        b_q <= bus.alu_B;
        op_q <= bus.alu_opcode;
      end
      tag_v <= {tag_v[LAT-2:0], acc};
      tag_id <= {tag_id[LAT-2:0], win};
      cnt0 <= cnt0 + CW'(acc && !win) - CW'(done0);
      cnt1 <= cnt1 + CW'(acc && win) - CW'(done1);
      bus.rsp_valid <= tag_v[LAT-1];
      if (tag_v[LAT-1]) begin
        bus.rsp_id <= tag_id[LAT-1];
        bus.rsp_result <= bus.alu_result;
        {bus.rsp_Z, bus.rsp_C, bus.rsp_Nf, bus.rsp_V} <= {bus.alu_Z, bus.alu_C, bus.alu_Nf, bus.alu_V};
      end
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall0_cnt <= '0;
      stall1_cnt <= '0;
    end else begin
      if (bus.req0_valid && !bus.req0_ready && stall0_cnt != 16'hFFFF) stall0_cnt <= stall0_cnt + 16'd1;
      if (bus.req1_valid && !bus.req1_ready && stall1_cnt != 16'hFFFF) stall1_cnt <= stall1_cnt + 16'd1;
    end
  end
`endif
endmodule
